// File: rtl/irq_ext_capture.sv
// irq_ext_capture: external interrupt front end for the vectored interrupt controller.
// Synchronises the raw lines and applies per-line enable, level/edge mode and polarity.
// Edge events are latched as pending bits until the VIC acknowledges them by index.
// Optional glitch filter: define IRQ_FILTER_EN to place a FILT_CYC-cycle stability filter
// between the synchroniser and the polarity stage.
module irq_ext_capture #(
  parameter int N_LINES  = 31,
  parameter int FILT_CYC = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_LINES-1:0] i_ext,
  input  logic               i_cfg_we,
  input  logic [4:0]         i_cfg_addr,
  input  logic [3:0]         i_cfg_data,
  input  logic               i_ack,
  input  logic [4:0]         i_ack_id,
  output logic [N_LINES-1:0] o_pending,
  output logic               o_irq_any
);

  if (N_LINES < 1 || N_LINES > 32) begin : g_bad_lines
    $error("irq_ext_capture: N_LINES out of range 1..32");
  end
  if (FILT_CYC < 1 || FILT_CYC > 15) begin : g_bad_filt
    $error("irq_ext_capture: FILT_CYC out of range 1..15");
  end

  localparam logic [5:0] NL = 6'(N_LINES);

  logic [3:0]         cfg_q [N_LINES];
  logic [N_LINES-1:0] s1_q, s2_q;
  logic [N_LINES-1:0] ap_q, ap_d;
  logic [N_LINES-1:0] pend_q, pend_d;
  logic               irq_any_q;
  logic [N_LINES-1:0] f;
  logic [N_LINES-1:0] a, a_new, evt, wr_hit, ack_hit;
  logic               cfg_ok, ack_ok;

  assign cfg_ok = i_cfg_we && ({1'b0, i_cfg_addr} < NL);
  assign ack_ok = i_ack && ({1'b0, i_ack_id} < NL);

  // Two-flop synchroniser per line
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_ext;
      s2_q <= s1_q;
    end
  end

`ifdef IRQ_FILTER_EN
  logic [N_LINES-1:0] f_q, f_d;
  logic [3:0]         cnt_q [N_LINES];
  logic [3:0]         cnt_d [N_LINES];

  // Stability filter: reload the down-counter while s2 matches f, accept s2 at terminal count
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < N_LINES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == f_q[i]) begin
        cnt_d[i] = 4'(FILT_CYC - 1);
      end else if (cnt_q[i] == 4'd0) begin
        f_d[i]   = s2_q[i];
        cnt_d[i] = 4'(FILT_CYC - 1);
      end else begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      f_q <= '0;
      for (int i = 0; i < N_LINES; i++) cnt_q[i] <= 4'd0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < N_LINES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign f = f_q;
`else
  assign f = s2_q;
`endif

  // Per-line polarity, event detection and next pending/previous-value state
  always_comb begin
    ap_d    = '0;
    pend_d  = '0;
    a       = '0;
    a_new   = '0;
    evt     = '0;
    wr_hit  = '0;
    ack_hit = '0;
    for (int i = 0; i < N_LINES; i++) begin
      wr_hit[i]  = cfg_ok && (i_cfg_addr == 5'(i));
      ack_hit[i] = ack_ok && (i_ack_id == 5'(i));
      a[i]       = f[i] ^ cfg_q[i][2];
      a_new[i]   = f[i] ^ i_cfg_data[2];
      evt[i]     = cfg_q[i][3] ? (a[i] ^ ap_q[i]) : (a[i] & ~ap_q[i]);
      if (wr_hit[i]) begin
        // New config: drop pending and re-baseline so a polarity flip is not seen as an edge
        ap_d[i]   = a_new[i];
        pend_d[i] = 1'b0;
      end else begin
        ap_d[i] = a[i];
        if (!cfg_q[i][1]) pend_d[i] = cfg_q[i][0] & a[i];
        else              pend_d[i] = cfg_q[i][0] & (evt[i] | (pend_q[i] & ~ack_hit[i]));
      end
    end
  end

  // Config, edge-history and pending registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < N_LINES; i++) cfg_q[i] <= 4'd0;
      ap_q      <= '0;
      pend_q    <= '0;
      irq_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_LINES; i++) begin
        if (wr_hit[i]) cfg_q[i] <= i_cfg_data;
      end
      ap_q      <= ap_d;
      pend_q    <= pend_d;
      irq_any_q <= |pend_q;
    end
  end

  assign o_pending = pend_q;
  assign o_irq_any = irq_any_q;

endmodule

// File: tb/tb_irq_ext_capture.sv
// Directed bench for irq_ext_capture with hand-computed expected values.
module tb_irq_ext_capture;

  logic        clk;
  logic        rst;
  logic [30:0] ext;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        ack;
  logic [4:0]  ack_id;
  logic [30:0] pending;
  logic        irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ext_capture #(.N_LINES(31), .FILT_CYC(3)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ext      (ext),
    .i_cfg_we   (cfg_we),
    .i_cfg_addr (cfg_addr),
    .i_cfg_data (cfg_data),
    .i_ack      (ack),
    .i_ack_id   (ack_id),
    .o_pending  (pending),
    .o_irq_any  (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards are sampled at the next edge
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_wr(input logic [4:0] addr, input logic [3:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_ack(input logic [4:0] id);
    ack = 1'b1; ack_id = id;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; ext = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    ack = 1'b0; ack_id = '0;
    do_reset();
    check("rst_pending", {1'b0, pending}, 32'h0);
    check("rst_irq_any", {31'b0, irq_any}, 32'h0);

`ifdef IRQ_FILTER_EN
    cfg_wr(5'd3, 4'b0011);
    // 2-cycle pulse is filtered out
    ext[3] = 1'b1; tick(2); ext[3] = 1'b0;
    tick(6);
    check("filt_short", {1'b0, pending}, 32'h0);
    // 3-cycle pulse passes, pending after edge 5
    ext[3] = 1'b1; tick(3); ext[3] = 1'b0;
    tick(2);
    check("filt_e4", {1'b0, pending}, 32'h0);
    tick();
    check("filt_e5", {1'b0, pending}, 32'h8);
    do_ack(5'd3);
    check("filt_ack", {1'b0, pending}, 32'h0);
    // Reset while the counter is running
    tick(6);
    ext[3] = 1'b1; tick(3);
    rst = 1'b0; tick(); rst = 1'b1;
    check("filt_rst_pend", {1'b0, pending}, 32'h0);
    check("filt_rst_any", {31'b0, irq_any}, 32'h0);
    tick(10);
    check("filt_after_rst", {1'b0, pending}, 32'h0);
    cfg_wr(5'd3, 4'b0011);
    tick(6);
    check("filt_cfg_static", {1'b0, pending}, 32'h0);
    check("filt_any_static", {31'b0, irq_any}, 32'h0);
`else
    // 1: rising edge on line 3, latency and ack
    cfg_wr(5'd3, 4'b0011);
    ext[3] = 1'b1; tick(); ext[3] = 1'b0;
    tick();
    check("t1_e1", {1'b0, pending}, 32'h0);
    tick();
    check("t1_e2", {1'b0, pending}, 32'h8);
    check("t1_any_e2", {31'b0, irq_any}, 32'h0);
    tick();
    check("t1_any_e3", {31'b0, irq_any}, 32'h1);
    do_ack(5'd3);
    check("t1_ack", {1'b0, pending}, 32'h0);
    tick();
    check("t1_any_clr", {31'b0, irq_any}, 32'h0);

    // 2: level mode on line 5
    cfg_wr(5'd5, 4'b0001);
    ext[5] = 1'b1;
    tick(2);
    check("t2_e1", {1'b0, pending}, 32'h0);
    tick();
    check("t2_e2", {1'b0, pending}, 32'h20);
    do_ack(5'd5);
    check("t2_ack_noeff", {1'b0, pending}, 32'h20);
    tick(6);
    check("t2_held", {1'b0, pending}, 32'h20);
    ext[5] = 1'b0;
    tick(2);
    check("t2_rel_e1", {1'b0, pending}, 32'h20);
    tick();
    check("t2_rel_e2", {1'b0, pending}, 32'h0);

    // 3: both edges on line 0
    cfg_wr(5'd0, 4'b1011);
    ext[0] = 1'b1; tick(3);
    check("t3_rise", {1'b0, pending}, 32'h1);
    do_ack(5'd0);
    check("t3_ack1", {1'b0, pending}, 32'h0);
    ext[0] = 1'b0; tick(3);
    check("t3_fall", {1'b0, pending}, 32'h1);
    do_ack(5'd0);
    check("t3_ack2", {1'b0, pending}, 32'h0);
    ext[0] = 1'b1; tick(2);
    do_ack(5'd0);
    check("t3_set_wins", {1'b0, pending}, 32'h1);
    do_ack(5'd0);
    check("t3_ack3", {1'b0, pending}, 32'h0);

    // 4: inverted polarity on line 7, then polarity flip on a static line
    ext[7] = 1'b1; tick(3);
    cfg_wr(5'd7, 4'b0111);
    tick(2);
    check("t4_cfg_quiet", {1'b0, pending}, 32'h0);
    ext[7] = 1'b0; tick(); ext[7] = 1'b1;
    tick(2);
    check("t4_low_pulse", {1'b0, pending}, 32'h80);
    do_ack(5'd7);
    check("t4_ack", {1'b0, pending}, 32'h0);
    cfg_wr(5'd7, 4'b0011);
    tick(3);
    check("t4_flip_quiet", {1'b0, pending}, 32'h0);

    // 5: out-of-range write/ack and disabled line leave state alone
    ext[3] = 1'b1; tick(); ext[3] = 1'b0; tick(2);
    check("t5_pend3", {1'b0, pending}, 32'h8);
    cfg_wr(5'd31, 4'b1111);
    do_ack(5'd31);
    check("t5_oor", {1'b0, pending}, 32'h8);
    ext[2] = 1'b1; tick(4);
    check("t5_disabled", {1'b0, pending}, 32'h8);
    check("t5_any", {31'b0, irq_any}, 32'h1);
    cfg_wr(5'd3, 4'b0011);
    check("t5_wr_clears", {1'b0, pending}, 32'h0);
    ext[3] = 1'b1; tick(); ext[3] = 1'b0; tick(2);
    check("t5_pend3b", {1'b0, pending}, 32'h8);
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 4'b0011;
    ack = 1'b1; ack_id = 5'd3;
    tick();
    cfg_we = 1'b0; ack = 1'b0;
    check("t5_wr_ack", {1'b0, pending}, 32'h0);
    ext[3] = 1'b1; tick(); ext[3] = 1'b0; tick(2);
    check("t5_cfg_kept", {1'b0, pending}, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
